// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder/subtractor. One operand bit is processed per clock,
//   LSB first, through a single full-adder cell and a carry flip-flop.
//   A WIDTH-bit operation therefore takes WIDTH busy cycles followed by a
//   one-cycle done pulse. A new start is accepted in that done cycle, so
//   back-to-back operations repeat every WIDTH+1 cycles.
//
// Parameters
//   WIDTH  operand/result width in bits (2..64)
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request a new operation (sampled only while busy is low)
//   sub    0: a+b+cin, 1: a-b (sampled with start)
//   a, b   operands
//   cin    carry-in for addition (ignored when subtracting)
//   busy   operation in progress
//   done   one-cycle pulse, sum/cout/ovf hold the new result
//   sum    result, held until the next completed operation
//   cout   carry-out (add) or not-borrow, i.e. a>=b unsigned (sub)
//   ovf    signed overflow of the completed operation
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             bit_s;
  logic             carry_s;
  logic [WIDTH-1:0] sr_shift;

  // Full-add cell on the current LSBs of the operand shift registers.
  assign bit_s   = x_q[0] ^ y_q[0] ^ carry_q;
  assign carry_s = (x_q[0] & y_q[0]) | (carry_q & (x_q[0] ^ y_q[0]));

  // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign sr_shift = (sr_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    x_d     = x_q;
    y_d     = y_q;
    sr_d    = sr_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and force the carry-in.
          x_d     = a;
          y_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d     = x_q >> 1;
        y_d     = y_q >> 1;
        sr_d    = sr_shift;
        carry_d = carry_s;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q is the carry into the MSB, carry_s the carry out of it.
          sum_d   = sr_shift;
          cout_d  = carry_s;
          ovf_d   = carry_q ^ carry_s;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Operand and partial-result shift registers are always reloaded before use.
  always_ff @(posedge clk) begin
    x_q  <= x_d;
    y_q  <= y_d;
    sr_q <= sr_d;
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8 instance
  logic       st8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  // WIDTH=16 instance
  logic        st16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  // WIDTH=2 instance
  logic       st2 = 1'b0, sub2 = 1'b0, cin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(st16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .sub(sub2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

  // Last result the WIDTH=8 instance should be holding.
  logic [7:0] last8 = '0;
  logic       lco8 = 1'b0, lov8 = 1'b0;

  // Arithmetic reference: unsigned result/carry plus signed range check.
  function automatic void model(input int w, input logic s,
                                input longint unsigned a, input longint unsigned b,
                                input logic c, output longint unsigned r,
                                output logic co, output logic ov);
    longint unsigned mask, tot;
    longint sa, sb, sr, lim;
    mask = (64'd1 << w) - 64'd1;
    lim  = longint'(64'd1 << (w - 1));
    sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    if (s) begin
      r  = (a - b) & mask;
      co = (a >= b);
      sr = sa - sb;
    end else begin
      tot = a + b + 64'(c);
      r   = tot & mask;
      co  = tot[w];
      sr  = sa + sb + longint'(64'(c));
    end
    ov = (sr >= lim) || (sr < -lim);
  endfunction

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      errors++;
      $display("FAIL reset8 got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    checks++;
    if ({busy16, done16, sum16, cout16, ovf16} !== 20'h0 ||
        {busy2, done2, sum2, cout2, ovf2} !== 6'h0) begin
      errors++;
      $display("FAIL reset16_2 got sum16=%h sum2=%h busy=%b/%b want all 0",
               sum16, sum2, busy16, busy2);
    end
    @(posedge clk); #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_held got busy=%b done=%b want 0/0", busy8, done8);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Runs one WIDTH=8 operation; caller sits 1 time unit after a clock edge.
  task automatic run_op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic [7:0] es, input logic eco,
                         input logic eov, input bit poke, input string nm);
    bit seen_bad_busy = 0, seen_bad_hold = 0;
    st8 = 1'b1; sub8 = s; a8 = a; b8 = b; cin8 = c;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      st8  = (poke && i == 2);
      sub8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      if (busy8 !== 1'b1 || done8 !== 1'b0) seen_bad_busy = 1;
      if (sum8 !== last8 || cout8 !== lco8 || ovf8 !== lov8) seen_bad_hold = 1;
      @(posedge clk); #1;
    end
    st8 = 1'b0;
    checks++;
    if (seen_bad_busy) begin
      errors++;
      $display("FAIL %s busy_window got a cycle with busy!=1 or done!=0 want busy=1 done=0", nm);
    end
    checks++;
    if (seen_bad_hold) begin
      errors++;
      $display("FAIL %s hold got sum changed before done want %h held", nm, last8);
    end
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle got done=%b busy=%b want 1/0", nm, done8, busy8);
    end
    checks++;
    if (sum8 !== es || cout8 !== eco || ovf8 !== eov) begin
      errors++;
      $display("FAIL %s result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               nm, sum8, cout8, ovf8, es, eco, eov);
    end
    last8 = es; lco8 = eco; lov8 = eov;
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== es) begin
      errors++;
      $display("FAIL %s after_done got done=%b busy=%b sum=%h want 0/0/%h",
               nm, done8, busy8, sum8, es);
    end
  endtask

  task automatic test_vectors();
    run_op8(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0, "add_5a_3c");
    run_op8(1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 0, "add_ff_01_cin");
    run_op8(1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 0, "sub_10_20");
    run_op8(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 0, "sub_80_01");
  endtask

  task automatic test_start_while_busy();
    run_op8(1'b0, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1, "start_ignored");
  endtask

  task automatic test_random8();
    longint unsigned r;
    logic co, ov, s, c;
    logic [7:0] a, b;
    for (int k = 0; k < 12; k++) begin
      s = 1'($urandom); c = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      if (k == 0) begin a = 8'h00; b = 8'h00; end
      if (k == 1) begin a = 8'h7F; b = 8'h7F; s = 1'b0; end
      model(8, s, 64'(a), 64'(b), c, r, co, ov);
      run_op8(s, a, b, c, r[7:0], co, ov, 0, "random8");
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_done = 0;
    longint unsigned r;
    logic co, ov;
    run_op8(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 0, "pre_abort");
    st8 = 1'b1; sub8 = 1'b0; a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      errors++;
      $display("FAIL abort_async got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done8 !== 1'b0 || busy8 !== 1'b0) saw_done = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done got done or busy after abort want none");
    end
    last8 = '0; lco8 = 1'b0; lov8 = 1'b0;
    model(8, 1'b0, 64'h9C, 64'h27, 1'b1, r, co, ov);
    run_op8(1'b0, 8'h9C, 8'h27, 1'b1, r[7:0], co, ov, 0, "after_abort");
  endtask

  // start held high; operands change every cycle. Whatever is on the inputs
  // in a cycle where busy is low is what the next edge must latch.
  task automatic test_back_to_back(input int w);
    longint unsigned qa[$], qb[$];
    logic qs[$], qc[$];
    longint unsigned ra, rb, sm, er, mask;
    logic rs, rc, bsy, dn, co, ov, eco, eov;
    int n_done = 0, last_done = -1, cyc = 0;
    bit bad_gap = 0;
    mask = (64'd1 << w) - 64'd1;
    while (n_done < 6 && cyc < 300) begin
      ra = {32'($urandom), 32'($urandom)} & mask;
      rb = {32'($urandom), 32'($urandom)} & mask;
      rs = 1'($urandom); rc = 1'($urandom);
      if (w == 16) begin
        st16 = 1'b1; sub16 = rs; a16 = ra[15:0]; b16 = rb[15:0]; cin16 = rc; bsy = busy16;
      end else begin
        st2 = 1'b1; sub2 = rs; a2 = ra[1:0]; b2 = rb[1:0]; cin2 = rc; bsy = busy2;
      end
      if (bsy === 1'b0) begin
        qa.push_back(ra); qb.push_back(rb); qs.push_back(rs); qc.push_back(rc);
      end
      @(posedge clk); #1;
      cyc++;
      if (w == 16) begin dn = done16; sm = 64'(sum16); co = cout16; ov = ovf16; end
      else         begin dn = done2;  sm = 64'(sum2);  co = cout2;  ov = ovf2;  end
      if (dn === 1'b1) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL b2b_w%0d unexpected done at cycle %0d want no done", w, cyc);
        end else begin
          model(w, qs[0], qa[0], qb[0], qc[0], er, eco, eov);
          void'(qa.pop_front()); void'(qb.pop_front());
          void'(qs.pop_front()); void'(qc.pop_front());
          if (sm !== er || co !== eco || ov !== eov) begin
            errors++;
            $display("FAIL b2b_w%0d result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     w, sm, co, ov, er, eco, eov);
          end
        end
        if (last_done >= 0 && cyc - last_done != w + 1) bad_gap = 1;
        last_done = cyc;
        n_done++;
      end
    end
    checks++;
    if (n_done < 6 || bad_gap) begin
      errors++;
      $display("FAIL b2b_w%0d cadence got %0d dones gap_error=%0d want 6 dones every %0d cycles",
               w, n_done, bad_gap, w + 1);
    end
    st16 = 1'b0; st2 = 1'b0;
    repeat (w + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_start_while_busy();
    test_random8();
    test_reset_mid_run();
    test_back_to_back(16);
    test_back_to_back(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a new operation; sampled only when busy==0.
REQ-005 Port: sub  input  1  mode: 0 = a+b+cin, 1 = a-b (two's complement); sampled with start.
REQ-006 Port: a  input  WIDTH  first operand, unsigned/two's complement.
REQ-007 Port: b  input  WIDTH  second operand.
REQ-008 Port: cin  input  1  carry-in; used only when sub==0.
REQ-009 Port: busy  output  1  high while an operation is in progress.
REQ-010 Port: done  output  1  single-cycle pulse, result valid.
REQ-011 Port: sum  output  WIDTH  result, held until the next result is written.
REQ-012 Port: cout  output  1  carry-out (sub==0); not-borrow, i.e. 1 when a>=b unsigned (sub==1).
REQ-013 Port: ovf  output  1  signed overflow of the completed operation.

Function
REQ-014 The block SHALL contain a two-state FSM: IDLE, RUN.
REQ-015 In IDLE with start==1 at a rising edge, the block SHALL latch a, b^{WIDTH{sub}}, carry = sub ? 1 : cin, clear the bit counter, and enter RUN.
REQ-016 Each RUN cycle SHALL process exactly one bit, LSB first, via a one-bit full-add (sum bit = x^y^c, carry = xy|c(x^y)), shifting the result bit into a WIDTH-bit shift register and storing the carry in a carry flip-flop.
REQ-017 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and RUN SHALL last exactly WIDTH cycles.
REQ-018 On the edge processing bit WIDTH-1, the block SHALL update sum, cout and ovf (ovf = carry into MSB XOR carry out of MSB), pulse done for one cycle, and return to IDLE.
REQ-019 Latency: start sampled at edge k -> done high and sum valid in the cycle following edge k+WIDTH.
REQ-020 busy SHALL be high exactly in the WIDTH cycles following the accepting edge, and low in the done cycle.
REQ-021 start while busy==1 SHALL be ignored with no effect on the operation in flight or on a, b, sub latching.
REQ-022 start high in the done cycle SHALL be accepted (back-to-back operation, no idle bubble).
REQ-023 Input changes on a, b, sub, cin after the accepting edge SHALL not affect the result.
REQ-024 sum, cout, ovf SHALL change only on the done edge; intermediate bits SHALL not be visible on sum.
REQ-025 Results SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-026 rst high SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, carry FF=0, independent of clk.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deassertion SHALL be processed normally.

Verification
REQ-028 WIDTH=8, sub=0, a=0x5A, b=0x3C, cin=0 -> after 8 busy cycles done=1, sum=0x96, cout=0, ovf=1.
REQ-029 WIDTH=8, sub=0, a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0.
REQ-030 WIDTH=8, sub=1, a=0x10, b=0x20 (cin=1 ignored) -> sum=0xF0, cout=0, ovf=0; a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-031 start pulsed again at cycle 3 of RUN with different operands -> ignored; first result unchanged, exactly one done.
REQ-032 rst asserted at RUN cycle 4 -> busy, done, sum, cout, ovf all 0 asynchronously; no done pulse afterwards.
REQ-033 start held high continuously, WIDTH=16, random operands -> one done every 17 cycles, every result matches a reference model; repeat for WIDTH=2.
